// File: rtl/urv_iram_arb.sv
// Purpose : shares instruction-RAM port B between the core data bus and a host/debug loader.
// Latency : grant is combinational (0 cycles); completion (rvalid/err/rdata) exactly 1 cycle after acceptance.
// Backpres: a requester not granted holds its inputs; weighted round-robin, host lock for RMW sequences.
//
// Ports:
//   clk_i, rst_n_i                 clock, async active-low reset
//   c_*  (req/we/addr/bwe/data in; gnt/rvalid/err/rdata out)   core data bus
//   h_*  (as core, plus h_lock_i)                              host/debug loader
//   ram_en_o/we_o/addr_o/bwe_o/data_o, ram_q_i                 RAM port B (1-cycle registered read)
module urv_iram_arb #(
    parameter int unsigned g_size        = 65536,
    parameter int unsigned g_core_weight = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        c_req_i,
    input  logic        c_we_i,
    input  logic [31:0] c_addr_i,
    input  logic [3:0]  c_bwe_i,
    input  logic [31:0] c_data_i,
    output logic        c_gnt_o,
    output logic        c_rvalid_o,
    output logic        c_err_o,
    output logic [31:0] c_rdata_o,

    input  logic        h_req_i,
    input  logic        h_we_i,
    input  logic        h_lock_i,
    input  logic [31:0] h_addr_i,
    input  logic [3:0]  h_bwe_i,
    input  logic [31:0] h_data_i,
    output logic        h_gnt_o,
    output logic        h_rvalid_o,
    output logic        h_err_o,
    output logic [31:0] h_rdata_o,

    output logic        ram_en_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_bwe_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_q_i
);

    localparam int unsigned AW     = $clog2(g_size);
    localparam logic [3:0]  WEIGHT = 4'(g_core_weight);

    logic       lock_q, lock_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic       pend_vld_q, pend_host_q, pend_we_q, pend_err_q;
    logic       pend_vld_d, pend_host_d, pend_we_d, pend_err_d;

    logic       contend;
    logic       c_in_range, h_in_range, win_in_range;
    logic       c_gnt, h_gnt;
    logic       rd_ok;

    assign contend    = c_req_i & h_req_i;
    assign c_in_range = (c_addr_i >> AW) == 32'd0;
    assign h_in_range = (h_addr_i >> AW) == 32'd0;

    // Grant decision. Gated by reset so no grant (and hence no RAM access)
    // is visible while the block is held in reset.
    always_comb begin
        c_gnt = 1'b0;
        h_gnt = 1'b0;
        if (rst_n_i) begin
            if (lock_q && h_req_i) begin
                h_gnt = 1'b1;
            end else if (contend) begin
                if (wcnt_q < WEIGHT) c_gnt = 1'b1;
                else                 h_gnt = 1'b1;
            end else begin
                c_gnt = c_req_i;
                h_gnt = h_req_i;
            end
        end
    end

    // Next state for lock, weight counter and the pending completion tag.
    always_comb begin
        lock_d = lock_q;
        if (!h_req_i)
            lock_d = 1'b0;
        else if (h_gnt)
            lock_d = h_lock_i;   // sets on a locked grant, clears on first unlocked one

        wcnt_d = wcnt_q;
        if (lock_q)
            wcnt_d = wcnt_q;     // held for the whole locked sequence
        else if (!contend)
            wcnt_d = 4'd0;
        else if (c_gnt)
            wcnt_d = wcnt_q + 4'd1;  // c_gnt under contention implies wcnt < weight: saturates
        else
            wcnt_d = 4'd0;

        pend_vld_d  = c_gnt | h_gnt;
        pend_host_d = h_gnt;
        pend_we_d   = h_gnt ? h_we_i : c_we_i;
        pend_err_d  = h_gnt ? ~h_in_range : ~c_in_range;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_q      <= 1'b0;
            wcnt_q      <= 4'd0;
            pend_vld_q  <= 1'b0;
            pend_host_q <= 1'b0;
            pend_we_q   <= 1'b0;
            pend_err_q  <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            wcnt_q      <= wcnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_host_q <= pend_host_d;
            pend_we_q   <= pend_we_d;
            pend_err_q  <= pend_err_d;
        end
    end

    // RAM port: winner forwarded only for in-range accesses, all zero otherwise.
    assign win_in_range = h_gnt ? h_in_range : c_in_range;

    always_comb begin
        ram_en_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = 32'd0;
        ram_bwe_o  = 4'd0;
        ram_data_o = 32'd0;
        if ((c_gnt | h_gnt) && win_in_range) begin
            ram_en_o   = 1'b1;
            ram_we_o   = h_gnt ? h_we_i   : c_we_i;
            ram_addr_o = h_gnt ? h_addr_i : c_addr_i;
            ram_bwe_o  = h_gnt ? h_bwe_i  : c_bwe_i;
            ram_data_o = h_gnt ? h_data_i : c_data_i;
        end
    end

    // Completion: read data only for an in-range read, routed to its requester.
    assign rd_ok      = pend_vld_q & ~pend_we_q & ~pend_err_q;
    assign c_gnt_o    = c_gnt;
    assign h_gnt_o    = h_gnt;
    assign c_rvalid_o = pend_vld_q & ~pend_host_q;
    assign h_rvalid_o = pend_vld_q &  pend_host_q;
    assign c_err_o    = c_rvalid_o & pend_err_q;
    assign h_err_o    = h_rvalid_o & pend_err_q;
    assign c_rdata_o  = (rd_ok & ~pend_host_q) ? ram_q_i : 32'd0;
    assign h_rdata_o  = (rd_ok &  pend_host_q) ? ram_q_i : 32'd0;

endmodule

// File: tb/tb_urv_iram_arb.sv
// Purpose : self-checking bench for urv_iram_arb with a behavioural RAM and completion scoreboard.
// Latency : expects grant same cycle, completion one cycle after acceptance.
// Backpres: requesters hold inputs until granted; bench advances on expected grants.
module tb_urv_iram_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, c_gnt, c_rvalid, c_err;
    logic [31:0] c_addr, c_data, c_rdata;
    logic [3:0]  c_bwe;
    logic        h_req, h_we, h_lock, h_gnt, h_rvalid, h_err;
    logic [31:0] h_addr, h_data, h_rdata;
    logic [3:0]  h_bwe;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_data, ram_q;
    logic [3:0]  ram_bwe;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        bit          host;
        int unsigned cyc;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mem     [0:16383];
    logic [31:0] ref_mem [0:16383];

    always #5 clk = ~clk;

    urv_iram_arb #(.g_size(65536), .g_core_weight(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_bwe_i(c_bwe), .c_data_i(c_data),
        .c_gnt_o(c_gnt), .c_rvalid_o(c_rvalid), .c_err_o(c_err), .c_rdata_o(c_rdata),
        .h_req_i(h_req), .h_we_i(h_we), .h_lock_i(h_lock), .h_addr_i(h_addr), .h_bwe_i(h_bwe),
        .h_data_i(h_data),
        .h_gnt_o(h_gnt), .h_rvalid_o(h_rvalid), .h_err_o(h_err), .h_rdata_o(h_rdata),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_bwe_o(ram_bwe),
        .ram_data_o(ram_data), .ram_q_i(ram_q)
    );

    // Behavioural RAM port B: registered read, byte-enabled write.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_bwe[b]) mem[ram_addr[15:2]][b*8 +: 8] <= ram_data[b*8 +: 8];
            end else begin
                ram_q <= mem[ram_addr[15:2]];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model of an accepted transfer: expected completion pushed now,
    // reference memory updated for in-range writes.
    task automatic sb_push(input bit host, input logic we, input logic [31:0] addr,
                           input logic [3:0] bwe, input logic [31:0] data);
        exp_t e;
        e.host  = host;
        e.cyc   = cyc + 1;
        e.err   = (addr >= 32'h0001_0000);
        e.rdata = (!we && !e.err) ? ref_mem[addr[15:2]] : 32'd0;
        if (we && !e.err)
            for (int b = 0; b < 4; b++)
                if (bwe[b]) ref_mem[addr[15:2]][b*8 +: 8] = data[b*8 +: 8];
        sb.push_back(e);
    endtask

    // Scoreboard: every cycle either the due completion or no rvalid at all.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                if (mon_e.host) begin
                    if ({h_rvalid, c_rvalid, h_err} !== {1'b1, 1'b0, mon_e.err} ||
                        h_rdata !== mon_e.rdata || c_rdata !== 32'd0) begin
                        errors++;
                        $display("FAIL host_completion cyc=%0d got rv=%b/%b err=%b rdata=%h c_rdata=%h want err=%b rdata=%h",
                                 cyc, h_rvalid, c_rvalid, h_err, h_rdata, c_rdata, mon_e.err, mon_e.rdata);
                    end
                end else begin
                    if ({c_rvalid, h_rvalid, c_err} !== {1'b1, 1'b0, mon_e.err} ||
                        c_rdata !== mon_e.rdata || h_rdata !== 32'd0) begin
                        errors++;
                        $display("FAIL core_completion cyc=%0d got rv=%b/%b err=%b rdata=%h h_rdata=%h want err=%b rdata=%h",
                                 cyc, c_rvalid, h_rvalid, c_err, c_rdata, h_rdata, mon_e.err, mon_e.rdata);
                    end
                end
            end else if (c_rvalid !== 1'b0 || h_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL spurious_rvalid cyc=%0d got c=%b h=%b want 0/0", cyc, c_rvalid, h_rvalid);
            end
            if (c_req && c_gnt === 1'b1) sb_push(1'b0, c_we, c_addr, c_bwe, c_data);
            if (h_req && h_gnt === 1'b1) sb_push(1'b1, h_we, h_addr, h_bwe, h_data);
        end
    end

    task automatic drive_core(input logic req, we, input logic [31:0] addr,
                              input logic [3:0] bwe, input logic [31:0] data);
        c_req = req; c_we = we; c_addr = addr; c_bwe = bwe; c_data = data;
    endtask

    task automatic drive_host(input logic req, we, lock, input logic [31:0] addr,
                              input logic [3:0] bwe, input logic [31:0] data);
        h_req = req; h_we = we; h_lock = lock; h_addr = addr; h_bwe = bwe; h_data = data;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_state;
        drive_core(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        drive_host(1'b1, 1'b1, 1'b1, 32'h20, 4'hF, 32'h55);
        @(negedge clk);
        checks++;
        if ({c_gnt, h_gnt, c_rvalid, h_rvalid, c_err, h_err, ram_en, ram_we} !== 8'd0 ||
            c_rdata !== 32'd0 || h_rdata !== 32'd0 || ram_addr !== 32'd0 ||
            ram_data !== 32'd0 || ram_bwe !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b/%b rv=%b/%b ram_en=%b ram_addr=%h want all zero",
                     c_gnt, h_gnt, c_rvalid, h_rvalid, ram_en, ram_addr);
        end
        drive_core(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_host(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        next_cycle;
        rst_n = 1'b1;
        next_cycle;
    endtask

    task automatic test_core_read;
        drive_host(1'b1, 1'b1, 1'b0, 32'h100, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if ({h_gnt, c_gnt, ram_en, ram_we} !== 4'b1011 || ram_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL host_write_grant got gnt=%b en=%b we=%b data=%h want 1/1/1 deadbeef",
                     h_gnt, ram_en, ram_we, ram_data);
        end
        next_cycle;
        drive_host(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_core(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if ({c_gnt, h_gnt, ram_en, ram_we} !== 4'b1010 || ram_addr !== 32'h100) begin
            errors++;
            $display("FAIL core_read_grant got gnt=%b en=%b we=%b addr=%h want 1/1/0 100",
                     c_gnt, ram_en, ram_we, ram_addr);
        end
        next_cycle;
        drive_core(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL core_read_data got rv=%b rdata=%h want 1 deadbeef", c_rvalid, c_rdata);
        end
        checks++;
        if ({c_gnt, h_gnt, ram_en, ram_we} !== 4'd0 || ram_addr !== 32'd0) begin
            errors++;
            $display("FAIL idle_ram got gnt=%b/%b en=%b addr=%h want all zero", c_gnt, h_gnt, ram_en, ram_addr);
        end
        next_cycle;
    endtask

    task automatic test_contention;
        logic [9:0] host_seq;
        int ci, hi;
        host_seq = 10'b10_0001_0000;
        ci = 0;
        hi = 0;
        drive_core(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_host(1'b1, 1'b0, 1'b0, 32'h100, 4'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({c_gnt, h_gnt} !== {~host_seq[i], host_seq[i]}) begin
                errors++;
                $display("FAIL contention_grant_%0d got c=%b h=%b want c=%b h=%b",
                         i, c_gnt, h_gnt, ~host_seq[i], host_seq[i]);
            end
            next_cycle;
            if (host_seq[i]) hi++;
            else             ci++;
            drive_core(1'b1, 1'b0, 32'(ci * 4), 4'h0, 32'h0);
            drive_host(1'b1, 1'b0, 1'b0, 32'h100 + 32'(hi * 4), 4'h0, 32'h0);
        end
        drive_core(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_host(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        next_cycle;
    endtask

    task automatic test_lock;
        drive_host(1'b1, 1'b0, 1'b1, 32'h40, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if ({h_gnt, c_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL lock_first got h=%b c=%b want 1/0", h_gnt, c_gnt);
        end
        next_cycle;
        drive_host(1'b1, 1'b1, 1'b0, 32'h40, 4'hF, 32'h12345678);
        drive_core(1'b1, 1'b0, 32'h44, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if ({h_gnt, c_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL lock_hold got h=%b c=%b want 1/0", h_gnt, c_gnt);
        end
        next_cycle;
        drive_host(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if ({h_gnt, c_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL lock_release got h=%b c=%b want 0/1", h_gnt, c_gnt);
        end
        next_cycle;
        drive_core(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        next_cycle;
        drive_core(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (c_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL lock_write_data got %h want 12345678", c_rdata);
        end
        next_cycle;
    endtask

    task automatic test_out_of_range;
        drive_core(1'b1, 1'b0, 32'h0001_0000, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if ({c_gnt, ram_en} !== 2'b10) begin
            errors++;
            $display("FAIL oor_grant got gnt=%b ram_en=%b want 1/0", c_gnt, ram_en);
        end
        next_cycle;
        drive_core(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if ({c_rvalid, c_err} !== 2'b11 || c_rdata !== 32'd0) begin
            errors++;
            $display("FAIL oor_completion got rv=%b err=%b rdata=%h want 1/1/0", c_rvalid, c_err, c_rdata);
        end
        next_cycle;
    endtask

    task automatic test_byte_write;
        drive_host(1'b1, 1'b1, 1'b0, 32'h200, 4'hF, 32'h11223344);
        next_cycle;
        drive_host(1'b1, 1'b1, 1'b0, 32'h200, 4'h1, 32'h000000AA);
        next_cycle;
        drive_host(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_core(1'b1, 1'b0, 32'h200, 4'h0, 32'h0);
        next_cycle;
        drive_core(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (c_rvalid !== 1'b1 || c_rdata !== 32'h112233AA) begin
            errors++;
            $display("FAIL byte_write got rv=%b rdata=%h want 1 112233aa", c_rvalid, c_rdata);
        end
        next_cycle;
    endtask

    task automatic test_reset_mid_op;
        // Four contended core grants push the weight counter to its limit.
        drive_core(1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
        drive_host(1'b1, 1'b0, 1'b0, 32'h100, 4'h0, 32'h0);
        repeat (4) next_cycle;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if ({c_gnt, h_gnt, c_rvalid, h_rvalid, c_err, h_err, ram_en} !== 7'd0 ||
            c_rdata !== 32'd0 || h_rdata !== 32'd0 || ram_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got gnt=%b/%b rv=%b/%b ram_en=%b want all zero",
                     c_gnt, h_gnt, c_rvalid, h_rvalid, ram_en);
        end
        drive_core(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_host(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        next_cycle;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (c_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard got rv=%b want 0", c_rvalid);
        end
        next_cycle;
        drive_core(1'b1, 1'b0, 32'hC, 4'h0, 32'h0);
        drive_host(1'b1, 1'b0, 1'b0, 32'h100, 4'h0, 32'h0);
        @(negedge clk);
        checks++;
        if ({c_gnt, h_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL reset_wcnt got c=%b h=%b want 1/0", c_gnt, h_gnt);
        end
        next_cycle;
        drive_core(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_host(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) next_cycle;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
        ram_q = 32'd0;
        rst_n = 1'b0;
        drive_core(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive_host(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (2) next_cycle;
        test_reset_state;
        test_core_read;
        test_contention;
        test_lock;
        test_out_of_range;
        test_byte_write;
        test_reset_mid_op;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
